// File: rtl/sig_seq_pkg.sv
// Shared definitions for the signal-port frame sequencer.
package sig_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  localparam int unsigned DROP_BITS = 16;
  localparam logic [DROP_BITS-1:0] DROP_MAX = '1;

endpackage

// File: rtl/sig_frame_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  MAX   = '1
) (
  input  logic             sig_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count register: reset/clear to zero, otherwise step up until MAX is reached.
  always_ff @(posedge sig_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sig_frame_sequencer.sv
// Frames free-running radio I/Q samples into valid/ready beats for the correlator.
// Samples arriving while the correlator stalls are dropped and counted.
module sig_frame_sequencer
  import sig_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = 105,
  parameter int unsigned CBITS     = 10,
  parameter int unsigned GAP       = 4,
  parameter int unsigned FBITS     = 8
) (
  input  logic                 sig_clk,
  input  logic                 rst_n,
  input  logic                 cfg_start_i,
  input  logic [FBITS-1:0]     cfg_nframes_i,
  input  logic                 cfg_abort_i,
  input  logic [WIDTH-1:0]     rad_idata_i,
  input  logic [WIDTH-1:0]     rad_qdata_i,
  output logic                 sig_valid_o,
  output logic                 sig_last_o,
  output logic [WIDTH-1:0]     sig_idata_o,
  output logic [WIDTH-1:0]     sig_qdata_o,
  input  logic                 sig_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [FBITS-1:0]     frames_o,
  output logic [DROP_BITS-1:0] drops_o,
  output logic                 overrun_o
);

  // The LOAD cycle is itself the final idle cycle between frames, so the
  // GAP state only covers the first GAP-1 idle cycles.
  localparam int unsigned GAP_LAST = (GAP >= 2) ? GAP - 2 : 0;
  localparam int unsigned GBITS    = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam logic [CBITS-1:0] LAST_IDX = CBITS'(FRAME_LEN - 1);

  seq_state_t         state_q, state_d;
  logic [FBITS-1:0]   nframes_q, nframes_d;
  logic               abort_pend_q, abort_pend_d;
  logic [CBITS-1:0]   beat_q, beat_d;
  logic [GBITS-1:0]   gap_q, gap_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   idata_q, idata_d;
  logic [WIDTH-1:0]   qdata_q, qdata_d;
  logic [FBITS-1:0]   frames_q, frames_d;
  logic               overrun_q, overrun_d;
  logic               drop_clr, drop_inc;
  logic               accept, stall, abort_now;
  logic [FBITS-1:0]   frames_inc;

  // State and output registers.
  always_ff @(posedge sig_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      nframes_q    <= '0;
      abort_pend_q <= 1'b0;
      beat_q       <= '0;
      gap_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      idata_q      <= '0;
      qdata_q      <= '0;
      frames_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      nframes_q    <= nframes_d;
      abort_pend_q <= abort_pend_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      idata_q      <= idata_d;
      qdata_q      <= qdata_d;
      frames_q     <= frames_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state, beat sequencing and drop accounting.
  always_comb begin
    state_d      = state_q;
    nframes_d    = nframes_q;
    abort_pend_d = abort_pend_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    valid_d      = valid_q;
    last_d       = last_q;
    idata_d      = idata_q;
    qdata_d      = qdata_q;
    frames_d     = frames_q;
    overrun_d    = overrun_q;
    drop_clr     = 1'b0;
    drop_inc     = 1'b0;
    accept       = valid_q & sig_ready_i;
    stall        = valid_q & ~sig_ready_i;
    abort_now    = abort_pend_q | cfg_abort_i;
    frames_inc   = frames_q + FBITS'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start_i && !cfg_abort_i) begin
          nframes_d    = cfg_nframes_i;
          frames_d     = '0;
          overrun_d    = 1'b0;
          abort_pend_d = 1'b0;
          drop_clr     = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idata_d      = rad_idata_i;
        qdata_d      = rad_qdata_i;
        valid_d      = 1'b1;
        beat_d       = '0;
        last_d       = abort_pend_q;
        abort_pend_d = abort_now;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        abort_pend_d = abort_now;
        if (accept) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            frames_d = frames_inc;
            if (abort_now || ((nframes_q != '0) && (frames_inc == nframes_q))) begin
              state_d = ST_DONE;
            end else if (GAP == 1) begin
              state_d = ST_LOAD;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end else begin
            beat_d  = beat_q + CBITS'(1);
            idata_d = rad_idata_i;
            qdata_d = rad_qdata_i;
            last_d  = ((beat_q + CBITS'(1)) == LAST_IDX) | abort_now;
          end
        end else if (stall) begin
          drop_inc  = 1'b1;
          overrun_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (cfg_abort_i) begin
          state_d = ST_DONE;
        end else if (gap_q == GBITS'(GAP_LAST)) begin
          state_d = ST_LOAD;
        end else begin
          gap_d = gap_q + GBITS'(1);
        end
      end
      ST_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(
    .WIDTH (DROP_BITS),
    .MAX   (DROP_MAX)
  ) u_drop_cnt (
    .sig_clk (sig_clk),
    .rst_n   (rst_n),
    .clr     (drop_clr),
    .inc     (drop_inc),
    .count   (drops_o)
  );

  assign sig_valid_o = valid_q;
  assign sig_last_o  = last_q;
  assign sig_idata_o = idata_q;
  assign sig_qdata_o = qdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign frames_o    = frames_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sig_frame_sequencer.sv
// Randomised scoreboard bench for sig_frame_sequencer.
module tb_sig_frame_sequencer;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 105;
  localparam int CBITS     = 10;
  localparam int GAP       = 4;
  localparam int FBITS     = 8;

  logic              sig_clk = 1'b0;
  logic              rst_n;
  logic              cfg_start_i;
  logic [FBITS-1:0]  cfg_nframes_i;
  logic              cfg_abort_i;
  logic [WIDTH-1:0]  rad_idata_i;
  logic [WIDTH-1:0]  rad_qdata_i;
  logic              sig_valid_o;
  logic              sig_last_o;
  logic [WIDTH-1:0]  sig_idata_o;
  logic [WIDTH-1:0]  sig_qdata_o;
  logic              sig_ready_i;
  logic              busy_o;
  logic              done_o;
  logic [FBITS-1:0]  frames_o;
  logic [15:0]       drops_o;
  logic              overrun_o;

  sig_frame_sequencer #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .CBITS     (CBITS),
    .GAP       (GAP),
    .FBITS     (FBITS)
  ) dut (
    .sig_clk       (sig_clk),
    .rst_n         (rst_n),
    .cfg_start_i   (cfg_start_i),
    .cfg_nframes_i (cfg_nframes_i),
    .cfg_abort_i   (cfg_abort_i),
    .rad_idata_i   (rad_idata_i),
    .rad_qdata_i   (rad_qdata_i),
    .sig_valid_o   (sig_valid_o),
    .sig_last_o    (sig_last_o),
    .sig_idata_o   (sig_idata_o),
    .sig_qdata_o   (sig_qdata_o),
    .sig_ready_i   (sig_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .frames_o      (frames_o),
    .drops_o       (drops_o),
    .overrun_o     (overrun_o)
  );

  always #5 sig_clk = ~sig_clk;

  typedef struct packed {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] q;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    rand_ready = 0;

  // Reference model: a session is a countdown of idle cycles followed by a frame
  // whose beats are the radio samples seen on each accepting cycle.
  bit               m_busy, m_done, m_valid, m_last, m_abort, m_ovr;
  logic [WIDTH-1:0] m_i, m_q;
  int               m_beat, m_load_in, m_nfr, m_frames, m_drops;

  // Inputs as they were at the most recent active edge.
  bit               p_rst, p_start, p_abort, p_ready;
  logic [WIDTH-1:0] p_i, p_q;
  int               p_nf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat();
    beat_t b;
    b.i = m_i;
    b.q = m_q;
    b.last = m_last;
    exp_q.push_back(b);
  endtask

  task automatic model_step();
    if (!p_rst) begin
      m_busy = 0; m_done = 0; m_valid = 0; m_last = 0; m_abort = 0; m_ovr = 0;
      m_i = '0; m_q = '0; m_beat = 0; m_load_in = 0; m_frames = 0; m_drops = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (p_start && !p_abort) begin
        m_busy = 1; m_nfr = p_nf; m_frames = 0; m_drops = 0; m_ovr = 0;
        m_abort = 0; m_load_in = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0; m_abort = 0;
    end else if (m_load_in > 0) begin
      if (m_load_in == 1) begin
        m_valid = 1; m_beat = 0; m_i = p_i; m_q = p_q; m_last = m_abort;
        push_beat();
        if (p_abort) m_abort = 1;
        m_load_in = 0;
      end else if (p_abort) begin
        m_done = 1;
      end else begin
        m_load_in--;
      end
    end else begin
      if (p_abort) m_abort = 1;
      if (p_ready) begin
        if (m_last) begin
          m_valid = 0; m_last = 0;
          m_frames = (m_frames + 1) % 256;
          if (m_abort || (m_nfr != 0 && m_frames == m_nfr)) m_done = 1;
          else m_load_in = GAP;
        end else begin
          m_beat++;
          m_i = p_i; m_q = p_q;
          m_last = (m_beat == FRAME_LEN - 1) || m_abort;
          push_beat();
        end
      end else begin
        if (m_drops < 65535) m_drops++;
        m_ovr = 1;
      end
    end
  endtask

  task automatic tick();
    p_rst = rst_n; p_start = cfg_start_i; p_abort = cfg_abort_i;
    p_ready = sig_ready_i; p_i = rad_idata_i; p_q = rad_qdata_i; p_nf = int'(cfg_nframes_i);
    @(posedge sig_clk);
    #1;
    model_step();
    chk("valid", sig_valid_o, m_valid);
    chk("last", sig_last_o, m_last);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    chk("frames", frames_o, m_frames);
    chk("drops", drops_o, m_drops);
    chk("overrun", overrun_o, m_ovr);
    rad_idata_i = WIDTH'($urandom);
    rad_qdata_i = WIDTH'($urandom);
    if (rand_ready) sig_ready_i = ($urandom_range(3, 0) != 0);
  endtask

  task automatic start_run(input int nf);
    cfg_nframes_i = FBITS'(nf);
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      tick();
      n++;
    end
    if (m_busy) timeout_fail("wait_idle");
  endtask

  task automatic run_until_beat(input int b, input int budget);
    int n = 0;
    while (!(m_valid && m_beat == b) && n < budget) begin
      tick();
      n++;
    end
    if (!(m_valid && m_beat == b)) timeout_fail("run_until_beat");
  endtask

  // Monitor: pops one expected beat per handshake and checks stall stability.
  bit               held_v = 0;
  logic [WIDTH-1:0] held_i, held_q;
  logic             held_last;
  always @(negedge sig_clk) begin
    if (rst_n && sig_valid_o) begin
      if (held_v) begin
        chk("stall_i_stable", sig_idata_o, held_i);
        chk("stall_q_stable", sig_qdata_o, held_q);
        chk("stall_last_stable", sig_last_o, held_last);
      end
      if (sig_ready_i) begin
        held_v = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_i", sig_idata_o, e.i);
          chk("beat_q", sig_qdata_o, e.q);
          chk("beat_last", sig_last_o, e.last);
        end
      end else begin
        held_v = 1;
        held_i = sig_idata_o;
        held_q = sig_qdata_o;
        held_last = sig_last_o;
      end
    end else begin
      held_v = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start_i = 1'b0; cfg_abort_i = 1'b0; cfg_nframes_i = '0;
    rad_idata_i = '0; rad_qdata_i = '0; sig_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Two complete frames with the correlator always ready.
    start_run(2);
    wait_idle(400);
    chk("t1_frames", frames_o, 2);
    chk("t1_busy", busy_o, 0);

    // Three-cycle stall on beat 20.
    start_run(1);
    run_until_beat(20, 200);
    sig_ready_i = 1'b0;
    repeat (3) tick();
    sig_ready_i = 1'b1;
    wait_idle(300);
    chk("t2_drops", drops_o, 3);
    chk("t2_overrun", overrun_o, 1);

    // Abort during beat 50 of a 4-frame run.
    start_run(4);
    run_until_beat(50, 200);
    cfg_abort_i = 1'b1;
    tick();
    cfg_abort_i = 1'b0;
    wait_idle(300);
    chk("t3_frames", frames_o, 1);

    // Continuous mode, abort in the gap after the third frame.
    begin
      int n = 0;
      start_run(0);
      while (m_frames < 3 && n < 600) begin
        tick();
        n++;
      end
      if (m_frames < 3) timeout_fail("t4_frames");
      cfg_abort_i = 1'b1;
      tick();
      cfg_abort_i = 1'b0;
      chk("t4_done", done_o, 1);
      wait_idle(20);
      chk("t4_frames", frames_o, 3);
    end

    // Reset mid-frame, then a fresh single frame.
    start_run(3);
    run_until_beat(30, 200);
    rst_n = 1'b0;
    tick();
    chk("t5_valid", sig_valid_o, 0);
    chk("t5_idata", sig_idata_o, 0);
    rst_n = 1'b1;
    tick();
    start_run(1);
    wait_idle(300);
    chk("t5_frames", frames_o, 1);
    chk("t5_drops", drops_o, 0);

    // Start while busy is ignored; start with abort in idle does nothing.
    start_run(2);
    run_until_beat(10, 200);
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    wait_idle(400);
    chk("t6_frames", frames_o, 2);
    cfg_start_i = 1'b1;
    cfg_abort_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    cfg_abort_i = 1'b0;
    tick();
    chk("t6_busy", busy_o, 0);

    // Randomised ready with occasional random aborts.
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      start_run(int'($urandom_range(3, 1)));
      if (r % 2 == 1) begin
        repeat ($urandom_range(250, 5)) tick();
        cfg_abort_i = 1'b1;
        tick();
        cfg_abort_i = 1'b0;
      end
      wait_idle(1500);
    end
    rand_ready = 0;
    sig_ready_i = 1'b1;
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
